acc_alu_bus: RTL and testbench

Parametrised accumulator ALU with a register-operand bus-request handshake. It is the next generation of the tiny accumulator core: configurable data and register-address widths, a full opcode set with flags, and a bus-timeout error path.
- It accepts one instruction at a time from the instruction port.
- For register-operand instructions it requests the operand from the external register block over a req/ack bus.
- It then updates the accumulator and flags in a single execute cycle.

---
 rtl/acc_alu_bus.sv | 194 +++++++++++++++++++
 tb/tb_acc_alu_bus.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu_bus.sv
// Accumulator ALU with register-operand req/ack bus and timeout abort.
// One instruction in flight; IDLE -> (REQ) -> EXEC -> IDLE.
module acc_alu_bus #(
   parameter int DATA_W     = 4,
   parameter int REG_ADDR_W = 4,
   parameter int TIMEOUT    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [3:0]            instr_op,
   input  logic [DATA_W-1:0]     instr_arg,
   output logic                  bus_req,
   output logic [REG_ADDR_W-1:0] bus_addr,
   input  logic                  bus_ack,
   input  logic [DATA_W-1:0]     bus_rdata,
   output logic [DATA_W-1:0]     acc,
   output logic                  flag_c,
   output logic                  flag_z,
   output logic                  flag_v,
   output logic                  done,
   output logic                  err,
   input  logic                  err_clr
);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_SUBI = 4'h2;
   localparam logic [3:0] OP_LDI  = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_SHL  = 4'hA;
   localparam logic [3:0] OP_SHR  = 4'hB;
   localparam logic [3:0] OP_CLR  = 4'hC;
   localparam logic [3:0] OP_ADC  = 4'hD;

   localparam int CW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam int TM1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] TMAX = CW'(TM1);
   localparam int MSB = DATA_W - 1;

   typedef enum logic [1:0] {IDLE, REQ, EXEC} state_t;

   state_t                state_q, state_d;
   logic [3:0]            op_q, op_d;
   logic [REG_ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     opnd_q, opnd_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]     acc_q, acc_d;
   logic                  c_q, c_d, z_q, z_d, v_q, v_d;
   logic                  done_q, done_d, err_q, err_d;

   logic [DATA_W:0]   sum_w, dif_w;
   logic [DATA_W-1:0] res_w;
   logic              rc_w, rv_w, cin_w;
   logic              is_reg, is_ill;

   assign instr_ready = ena && (state_q == IDLE);
   assign bus_req     = (state_q == REQ);
   assign bus_addr    = addr_q;
   assign acc         = acc_q;
   assign flag_c      = c_q;
   assign flag_z      = z_q;
   assign flag_v      = v_q;
   assign done        = done_q;
   assign err         = err_q;

   assign is_reg = instr_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                    OP_XOR, OP_LD, OP_ADC};
   assign is_ill = instr_op inside {4'hE, 4'hF};

   assign cin_w = (op_q == OP_ADC) ? c_q : 1'b0;
   assign sum_w = {1'b0, acc_q} + {1'b0, opnd_q} + {{DATA_W{1'b0}}, cin_w};
   assign dif_w = {1'b0, acc_q} - {1'b0, opnd_q};

   always_comb begin
      res_w = acc_q;
      rc_w  = 1'b0;
      rv_w  = 1'b0;
      unique case (op_q)
         OP_ADDI, OP_ADD, OP_ADC: begin
            res_w = sum_w[MSB:0];
            rc_w  = sum_w[DATA_W];
            rv_w  = (acc_q[MSB] == opnd_q[MSB]) && (res_w[MSB] != acc_q[MSB]);
         end
         OP_SUBI, OP_SUB: begin
            res_w = dif_w[MSB:0];
            rc_w  = dif_w[DATA_W];
            rv_w  = (acc_q[MSB] != opnd_q[MSB]) && (res_w[MSB] != acc_q[MSB]);
         end
         OP_LDI, OP_LD: res_w = opnd_q;
         OP_AND:        res_w = acc_q & opnd_q;
         OP_OR:         res_w = acc_q | opnd_q;
         OP_XOR:        res_w = acc_q ^ opnd_q;
         OP_SHL: begin
            res_w = {acc_q[MSB-1:0], 1'b0};
            rc_w  = acc_q[MSB];
         end
         OP_SHR: begin
            res_w = {1'b0, acc_q[MSB:1]};
            rc_w  = acc_q[0];
         end
         OP_CLR:  res_w = '0;
         default: res_w = acc_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      c_d     = c_q;
      z_d     = z_q;
      v_d     = v_q;
      done_d  = 1'b0;
      err_d   = err_q && !err_clr;
      unique case (state_q)
         IDLE: begin
            if (instr_valid && instr_ready) begin
               op_d   = instr_op;
               addr_d = instr_arg[REG_ADDR_W-1:0];
               opnd_d = instr_arg;
               cnt_d  = '0;
               if (is_ill)      err_d   = 1'b1;
               else if (is_reg) state_d = REQ;
               else             state_d = EXEC;
            end
         end
         REQ: begin
            // ack takes priority over an expiring timeout
            if (bus_ack) begin
               opnd_d  = bus_rdata;
               state_d = EXEC;
            end else if (TIMEOUT != 0) begin
               if (cnt_q == TMAX) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         EXEC: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (op_q != OP_NOP) begin
               acc_d = res_w;
               c_d   = rc_w;
               v_d   = rv_w;
               z_d   = (res_w == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         v_q     <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         z_q     <= z_d;
         v_q     <= v_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_acc_alu_bus.sv
// Directed bench for acc_alu_bus with hand-computed expectations.
`timescale 1ns/1ps
module tb_acc_alu_bus;

   logic       clk = 1'b0;
   logic       rst_n, ena, instr_valid, instr_ready;
   logic [3:0] instr_op, instr_arg;
   logic       bus_req, bus_ack;
   logic [3:0] bus_addr, bus_rdata, acc;
   logic       flag_c, flag_z, flag_v, done, err, err_clr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   acc_alu_bus #(.DATA_W(4), .REG_ADDR_W(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_arg(instr_arg),
      .bus_req(bus_req), .bus_addr(bus_addr),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v),
      .done(done), .err(err), .err_clr(err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // returns #1 after the accepting edge
   task automatic send(input logic [3:0] op, input logic [3:0] arg);
      int n = 0;
      @(negedge clk);
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("ready_wait", 0, 1);
      instr_valid = 1'b1;
      instr_op    = op;
      instr_arg   = arg;
      step();
      instr_valid = 1'b0;
   endtask

   task automatic imm(input string tag, input logic [3:0] op,
                      input logic [3:0] arg);
      send(op, arg);
      step();
      chk({tag, "_done"}, done, 1);
   endtask

   task automatic reg_op(input string tag, input logic [3:0] op,
                         input logic [3:0] a, input logic [3:0] d);
      send(op, a);
      chk({tag, "_req"}, bus_req, 1);
      chk({tag, "_addr"}, bus_addr, a);
      bus_ack   = 1'b1;
      bus_rdata = d;
      step();
      bus_ack = 1'b0;
      step();
      chk({tag, "_done"}, done, 1);
   endtask

   int hi, dn, dcyc;

   initial begin
      rst_n = 1'b0; ena = 1'b1; instr_valid = 1'b0;
      instr_op = '0; instr_arg = '0;
      bus_ack = 1'b0; bus_rdata = '0; err_clr = 1'b0;
      #12;
      chk("rst_acc", acc, 0);
      chk("rst_flags", {flag_c, flag_z, flag_v}, 0);
      chk("rst_err", err, 0);
      chk("rst_req", bus_req, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      imm("ldi4", 4'h3, 4'h4);
      chk("ldi4_acc", acc, 4);
      imm("addi2", 4'h1, 4'h2);
      chk("addi2_acc", acc, 6);
      chk("addi2_cZV", {flag_c, flag_z, flag_v}, 3'b000);
      step();
      chk("done_pulse", done, 0);
      imm("addi3", 4'h1, 4'h3);
      chk("addi3_acc", acc, 9);
      chk("addi3_cZV", {flag_c, flag_z, flag_v}, 3'b001);

      // ADD reg 1, ack withheld for 3 cycles
      imm("ldi5", 4'h3, 4'h5);
      send(4'h4, 4'h1);
      chk("add_addr", bus_addr, 1);
      hi = 0; dn = 0; dcyc = -1;
      for (int i = 0; i < 7; i++) begin
         if (bus_req) hi++;
         if (done) begin dn++; dcyc = i; end
         if (i == 3) begin bus_ack = 1'b1; bus_rdata = 4'h4; end
         step();
         bus_ack = 1'b0;
      end
      chk("add_req_cycles", hi, 4);
      chk("add_done_count", dn, 1);
      chk("add_done_cycle", dcyc, 5);
      chk("add_acc", acc, 9);
      chk("add_cZV", {flag_c, flag_z, flag_v}, 3'b001);

      imm("ldiF", 4'h3, 4'hF);
      imm("addi1", 4'h1, 4'h1);
      chk("wrap_acc", acc, 0);
      chk("wrap_cZV", {flag_c, flag_z, flag_v}, 3'b110);
      imm("subi1", 4'h2, 4'h1);
      chk("subi_acc", acc, 4'hF);
      chk("subi_cZV", {flag_c, flag_z, flag_v}, 3'b100);
      imm("shr", 4'hB, 4'h0);
      chk("shr_acc", acc, 7);
      chk("shr_c", flag_c, 1);

      // LD reg 2, no ack ever
      send(4'h9, 4'h2);
      hi = 0; dn = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus_req) hi++;
         if (done) dn++;
         step();
      end
      chk("to_req_cycles", hi, 8);
      chk("to_done", dn, 0);
      chk("to_err", err, 1);
      chk("to_acc", acc, 7);
      chk("to_ready", instr_ready, 1);
      @(negedge clk);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("errclr", err, 0);

      send(4'hE, 4'h0);
      chk("ill_err", err, 1);
      chk("ill_acc", acc, 7);
      chk("ill_ready", instr_ready, 1);
      step();
      chk("ill_done", done, 0);
      @(negedge clk);
      err_clr = 1'b1;
      instr_valid = 1'b1;
      instr_op = 4'hF;
      step();
      instr_valid = 1'b0;
      err_clr = 1'b0;
      chk("clr_vs_set", err, 1);
      @(negedge clk);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("errclr2", err, 0);

      @(negedge clk);
      ena = 1'b0;
      instr_valid = 1'b1;
      instr_op = 4'hC;
      #1;
      chk("ena_ready", instr_ready, 0);
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) dn++;
      end
      chk("ena_done", dn, 0);
      chk("ena_acc", acc, 7);
      instr_valid = 1'b0;
      ena = 1'b1;

      imm("ldiA", 4'h3, 4'hA);
      imm("shl", 4'hA, 4'h0);
      chk("shl_acc", acc, 4);
      chk("shl_cZV", {flag_c, flag_z, flag_v}, 3'b100);
      reg_op("adc", 4'hD, 4'h5, 4'h2);
      chk("adc_acc", acc, 7);
      chk("adc_c", flag_c, 0);
      reg_op("xor", 4'h8, 4'h3, 4'h3);
      chk("xor_acc", acc, 4);
      reg_op("sub", 4'h5, 4'h1, 4'h5);
      chk("sub_acc", acc, 4'hF);
      chk("sub_cZV", {flag_c, flag_z, flag_v}, 3'b100);
      imm("nop", 4'h0, 4'h0);
      chk("nop_acc", acc, 4'hF);
      chk("nop_flags", {flag_c, flag_z, flag_v}, 3'b100);

      // async reset in REQ
      imm("ldi6", 4'h3, 4'h6);
      send(4'h9, 4'h3);
      chk("rq_req", bus_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req", bus_req, 0);
      chk("arst_acc", acc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      imm("ldi3", 4'h3, 4'h3);
      chk("post_rst_acc", acc, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
